mem_port_arbiter: RTL and testbench

- Shares one single-ported 32-bit word memory (datain/addr/we/dataout style) between two requesters: port 0 = instruction fetch, port 1 = load/store.
- Arbitrates between them, latches the winning request, sequences the memory's write strobe and read latency, and returns read data with a one-cycle ack pulse.
- Sits between the processor datapath and the memory instance.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported word memory between an
// instruction-fetch port (0) and a load/store port (1).
// Ties are resolved by port 1 fixed priority. If MEM_ARB_ROUND_ROBIN_EN is
// defined, ties go to the port that was not granted last.
// Ports:
//   clk, rst                       clock, async active-high reset
//   req/addr/we/wdata 0 and 1      requester inputs (req held until ack)
//   ack0, ack1                     one-cycle completion pulses
//   rdata                          read data, valid while an ack is high
//   busy                           high whenever the FSM is not IDLE
//   mem_addr/mem_datain/mem_we     memory request outputs
//   mem_dataout                    memory read data, RD_LAT cycles after address
module mem_port_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_datain,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dataout
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            port_q, port_d;
  logic            we_q, we_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            busy_q, busy_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_datain_q, mem_datain_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            gnt_c;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic            ptr_q, ptr_d;
`endif

  // Arbitration: a lone request always wins; a tie follows the tie rule.
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (req0 && req1) gnt_c = ~ptr_q;
    else              gnt_c = req1;
`else
    gnt_c = req1;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    port_d       = port_q;
    we_d         = we_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    rdata_d      = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // The memory outputs double as the latched address/data.
          port_d       = gnt_c;
          we_d         = gnt_c ? we1 : we0;
          mem_addr_d   = gnt_c ? addr1 : addr0;
          mem_datain_d = gnt_c ? wdata1 : wdata0;
          mem_we_d     = gnt_c ? we1 : we0;
          state_d      = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          ptr_d        = gnt_c;
`endif
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d = mem_dataout;
          state_d = DONE;
          ack0_d  = ~port_q;
          ack1_d  = port_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any transaction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      rdata_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      port_q       <= port_d;
      we_q         <= we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      rdata_q      <= rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign busy       = busy_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3),
// each attached to a behavioural memory, checked against a word-level model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif
  localparam int LAT_OF [2] = '{1, 3};

  logic        clk;
  logic        rst;
  logic        req0 [2];
  logic        req1 [2];
  logic        we0 [2];
  logic        we1 [2];
  logic        ack0 [2];
  logic        ack1 [2];
  logic        busy [2];
  logic        mwe [2];
  logic [31:0] addr0 [2];
  logic [31:0] addr1 [2];
  logic [31:0] wdata0 [2];
  logic [31:0] wdata1 [2];
  logic [31:0] rdata [2];
  logic [31:0] maddr [2];
  logic [31:0] mdin [2];
  logic [31:0] mdout [2];

  int errors = 0;
  int checks = 0;

  // Reference model: memory contents and last read data per instance.
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rd [2];

  // Observations of the most recent transaction.
  int          t_lat;
  bit          t_ap;
  logic [31:0] t_rd;
  int          t_nwe;
  logic [31:0] t_wa;
  logic [31:0] t_wd;
  int          t_nb;
  bit          t_extra;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [256];
    logic [31:0] pipe [LAT];
    logic        mem_init = 1'b0;

    // Memory: write on mem_we, read data appears LAT cycles after the address edge.
    always @(posedge clk) begin
      if (!mem_init) begin
        for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
        for (int k = 0; k < int'(LAT); k++) pipe[k] <= 32'h0;
        mem_init <= 1'b1;
      end else begin
        if (mwe[g]) mem[maddr[g][7:0]] <= mdin[g];
        pipe[0] <= mem[maddr[g][7:0]];
        for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
      end
    end
    assign mdout[g] = pipe[LAT-1];

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0[g]),
      .addr0      (addr0[g]),
      .we0        (we0[g]),
      .wdata0     (wdata0[g]),
      .ack0       (ack0[g]),
      .req1       (req1[g]),
      .addr1      (addr1[g]),
      .we1        (we1[g]),
      .wdata1     (wdata1[g]),
      .ack1       (ack1[g]),
      .rdata      (rdata[g]),
      .busy       (busy[g]),
      .mem_addr   (maddr[g]),
      .mem_datain (mdin[g]),
      .mem_we     (mwe[g]),
      .mem_dataout(mdout[g])
    );
  end

  task automatic drive(input int d, input bit p, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      req1[d] = r; we1[d] = w; addr1[d] = a; wdata1[d] = wd;
    end else begin
      req0[d] = r; we0[d] = w; addr0[d] = a; wdata0[d] = wd;
    end
  endtask

  // Issue one request from IDLE and record what the DUT did until its ack.
  task automatic run_txn(input int d, input bit p, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input bit drop);
    t_lat = -1; t_ap = 1'b0; t_rd = '0; t_nwe = 0; t_wa = '0; t_wd = '0;
    t_nb = 0; t_extra = 1'b0;
    @(negedge clk);
    drive(d, p, 1'b1, w, a, wd);
    @(posedge clk);
    for (int c = 1; c <= 30; c++) begin
      #1;
      if (c == 1 && drop) drive(d, p, 1'b0, w, 32'h20, 32'h0);
      if (mwe[d]) begin t_nwe++; t_wa = maddr[d]; t_wd = mdin[d]; end
      if (busy[d]) t_nb++;
      if (ack0[d] && ack1[d]) t_extra = 1'b1;
      if (ack0[d] || ack1[d]) begin
        t_lat = c; t_ap = ack1[d]; t_rd = rdata[d];
        break;
      end
      @(posedge clk);
    end
    drive(d, p, 1'b0, w, a, wd);
    @(posedge clk); #1;
    if (ack0[d] || ack1[d] || busy[d] || mwe[d]) t_extra = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack0[d] !== 1'b0) begin errors++; $display("FAIL reset_ack0[%0d]: got %b want 0", d, ack0[d]); end
      checks++; if (ack1[d] !== 1'b0) begin errors++; $display("FAIL reset_ack1[%0d]: got %b want 0", d, ack1[d]); end
      checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
      checks++; if (mwe[d] !== 1'b0) begin errors++; $display("FAIL reset_mem_we[%0d]: got %b want 0", d, mwe[d]); end
      checks++; if (maddr[d] !== 32'h0) begin errors++; $display("FAIL reset_mem_addr[%0d]: got %h want 0", d, maddr[d]); end
      checks++; if (mdin[d] !== 32'h0) begin errors++; $display("FAIL reset_mem_datain[%0d]: got %h want 0", d, mdin[d]); end
      checks++; if (rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata[d]); end
    end
  endtask

  task automatic test_write();
    run_txn(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    ref_mem[0][8'h10] = 32'hDEADBEEF;
    checks++; if (t_lat != 2) begin errors++; $display("FAIL write_latency: got %0d want 2", t_lat); end
    checks++; if (t_ap !== 1'b1) begin errors++; $display("FAIL write_ack_port: got %0d want 1", t_ap); end
    checks++; if (t_nwe != 1) begin errors++; $display("FAIL write_we_cycles: got %0d want 1", t_nwe); end
    checks++; if (t_wa !== 32'h10) begin errors++; $display("FAIL write_addr: got %h want 10", t_wa); end
    checks++; if (t_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data: got %h want deadbeef", t_wd); end
    checks++; if (t_nb != 2) begin errors++; $display("FAIL write_busy: got %0d want 2", t_nb); end
    checks++; if (t_extra !== 1'b0) begin errors++; $display("FAIL write_extra_ack: got %b want 0", t_extra); end
  endtask

  task automatic test_readback();
    run_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    last_rd[0] = ref_mem[0][8'h10];
    checks++; if (t_lat != 3) begin errors++; $display("FAIL readback_latency: got %0d want 3", t_lat); end
    checks++; if (t_ap !== 1'b0) begin errors++; $display("FAIL readback_ack_port: got %0d want 0", t_ap); end
    checks++; if (t_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_rdata: got %h want deadbeef", t_rd); end
    checks++; if (t_nwe != 0) begin errors++; $display("FAIL readback_mem_we: got %0d want 0", t_nwe); end
  endtask

  task automatic test_lat3();
    run_txn(1, 1'b1, 1'b1, 32'h4, 32'h12345678, 1'b0);
    ref_mem[1][8'h04] = 32'h12345678;
    checks++; if (t_lat != 2) begin errors++; $display("FAIL lat3_write_latency: got %0d want 2", t_lat); end
    run_txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    last_rd[1] = 32'h12345678;
    checks++; if (t_lat != 5) begin errors++; $display("FAIL lat3_read_latency: got %0d want 5", t_lat); end
    checks++; if (t_nb != 5) begin errors++; $display("FAIL lat3_busy: got %0d want 5", t_nb); end
    checks++; if (t_ap !== 1'b1) begin errors++; $display("FAIL lat3_ack_port: got %0d want 1", t_ap); end
    checks++; if (t_rd !== 32'h12345678) begin errors++; $display("FAIL lat3_rdata: got %h want 12345678", t_rd); end
  endtask

  task automatic test_tie();
    bit got [4];
    int n = 0;
    bit both = 1'b0;
    pulse_reset();
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b1, 32'h40, 32'hA0A00000);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h44, 32'hB1B10000);
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(posedge clk); #1;
      if (ack0[0] && ack1[0]) both = 1'b1;
      if (ack0[0] || ack1[0]) begin got[n] = ack1[0]; n++; end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++; if (n != 4) begin errors++; $display("FAIL tie_count: got %0d want 4", n); end
    for (int k = 0; k < n; k++) begin
      bit exp_p = RR_EN ? ((k % 2) == 0) : 1'b1;
      if (got[k]) ref_mem[0][8'h44] = 32'hB1B10000;
      else        ref_mem[0][8'h40] = 32'hA0A00000;
      checks++; if (got[k] !== exp_p) begin errors++; $display("FAIL tie_grant[%0d]: got %0d want %0d", k, got[k], exp_p); end
    end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL tie_dual_ack: got %b want 0", both); end
  endtask

  task automatic test_async_reset();
    bit late = 1'b0;
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL areset_busy_before: got %b want 1", busy[1]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy[1]); end
    checks++; if (mwe[1] !== 1'b0) begin errors++; $display("FAIL areset_mem_we: got %b want 0", mwe[1]); end
    checks++; if ((ack0[1] | ack1[1]) !== 1'b0) begin errors++; $display("FAIL areset_ack: got %b%b want 00", ack0[1], ack1[1]); end
    checks++; if (rdata[1] !== 32'h0) begin errors++; $display("FAIL areset_rdata: got %h want 0", rdata[1]); end
    drive(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack0[1] || ack1[1] || busy[1]) late = 1'b1;
    end
    checks++; if (late !== 1'b0) begin errors++; $display("FAIL areset_late_ack: got %b want 0", late); end
    run_txn(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    last_rd[1] = ref_mem[1][8'h04];
    checks++; if (t_lat != 5) begin errors++; $display("FAIL areset_next_latency: got %0d want 5", t_lat); end
    checks++; if (t_rd !== 32'h12345678) begin errors++; $display("FAIL areset_next_rdata: got %h want 12345678", t_rd); end
  endtask

  task automatic test_addr_change();
    run_txn(0, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b1);
    ref_mem[0][8'h10] = 32'hCAFEF00D;
    checks++; if (t_lat != 2) begin errors++; $display("FAIL drop_latency: got %0d want 2", t_lat); end
    checks++; if (t_ap !== 1'b0) begin errors++; $display("FAIL drop_ack_port: got %0d want 0", t_ap); end
    checks++; if (t_wa !== 32'h10) begin errors++; $display("FAIL drop_addr: got %h want 10", t_wa); end
    checks++; if (t_wd !== 32'hCAFEF00D) begin errors++; $display("FAIL drop_data: got %h want cafef00d", t_wd); end
    checks++; if (t_extra !== 1'b0) begin errors++; $display("FAIL drop_extra_ack: got %b want 0", t_extra); end
    run_txn(0, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    last_rd[0] = ref_mem[0][8'h20];
    checks++; if (t_rd !== ref_mem[0][8'h20]) begin errors++; $display("FAIL drop_no_write_20: got %h want %h", t_rd, ref_mem[0][8'h20]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int          d = int'($urandom_range(0, 1));
      bit          p = 1'($urandom_range(0, 1));
      bit          w = 1'($urandom_range(0, 1));
      logic [31:0] a = 32'($urandom_range(0, 31)) << 2;
      logic [31:0] wd = 32'($urandom);
      int          exp_lat = w ? 2 : LAT_OF[d] + 2;
      logic [31:0] exp_rd = w ? last_rd[d] : ref_mem[d][a[7:0]];
      run_txn(d, p, w, a, wd, 1'b0);
      if (w) ref_mem[d][a[7:0]] = wd;
      else   last_rd[d] = exp_rd;
      checks++; if (t_lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, t_lat, exp_lat); end
      checks++; if (t_ap !== p) begin errors++; $display("FAIL rand%0d_ack_port: got %0d want %0d", i, t_ap, p); end
      checks++; if (t_rd !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", i, t_rd, exp_rd); end
      checks++; if (t_nwe != int'(w)) begin errors++; $display("FAIL rand%0d_we_cycles: got %0d want %0d", i, t_nwe, w); end
      checks++; if (t_extra !== 1'b0) begin errors++; $display("FAIL rand%0d_extra_ack: got %b want 0", i, t_extra); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(d, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      last_rd[d] = 32'h0;
      for (int k = 0; k < 256; k++) ref_mem[d][k] = 32'h0;
    end
    #12;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_write();
    test_readback();
    test_lat3();
    test_tie();
    test_async_reset();
    test_addr_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
